spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_master_shifter.sv | 34 +++
 rtl/spi_master.sv | 180 ++++++++++++++++++
 tb/tb_spi_master.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: command codes, FSM state encoding,
// frame/data widths and the frame-building helper.
package spi_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;
    localparam int CMD_W   = 2;

    localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
    localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TURN  = 3'd3,
        ST_RECV  = 3'd4,
        ST_END   = 3'd5
    } state_t;

    // Frame layout on the wire: command code first, then payload, MSB first.
    function automatic logic [FRAME_W-1:0] make_frame(input logic [CMD_W-1:0] c,
                                                      input logic [DATA_W-1:0] d);
        return {c, d};
    endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// 10-bit parallel-load shift register. Serial out is the MSB; serial in
// enters at the LSB. o_rx_byte presents the low byte as it will look after
// the current shift, so the final received bit can be captured in the same
// edge that samples it.
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [FRAME_W-1:0] i_load_val,
    input  logic               i_shift,
    input  logic               i_sin,
    output logic               o_sout,
    output logic [DATA_W-1:0]  o_rx_byte
);

    logic [FRAME_W-1:0] r_sr;

    // Load has priority over shift; both are one-cycle operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_load_val;
        end else if (i_shift) begin
            r_sr <= {r_sr[FRAME_W-2:0], i_sin};
        end
    end

    assign o_sout    = r_sr[FRAME_W-1];
    assign o_rx_byte = {r_sr[DATA_W-2:0], i_sin};

endmodule

// File: rtl/spi_master.sv
// SPI master: one command per frame, 10-bit command/payload frame shifted
// MSB first, with an optional turnaround and 8-bit receive for rd-data.
// Optional feature: define SPI_MASTER_RDCHK_EN to require a rd-addr before
// every rd-data; an unpaired rd-data is dropped and seq_err latches high.
module spi_master
    import spi_pkg::*;
#(
    parameter int TURNAROUND = 2
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO,
    output logic              seq_err
);

    localparam logic [3:0] SHIFT_LAST = 4'(FRAME_W - 1);
    localparam logic [3:0] TURN_LAST  = 4'(TURNAROUND - 1);
    localparam logic [3:0] RECV_LAST  = 4'(DATA_W - 1);

    state_t            r_state;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_ss_n;
    logic              r_mosi;
    logic              r_is_read;
    logic [3:0]        r_cnt;

    logic              w_handshake;
    logic              w_drop;
    logic              w_load;
    logic              w_shift;
    logic              w_sin;
    logic              w_sout;
    logic [DATA_W-1:0] w_rx_byte;

    // cmd_ready is a register cleared by reset, so it is only seen in IDLE.
    assign w_handshake = cmd_valid & r_cmd_ready;
    assign w_load      = w_handshake & ~w_drop;
    assign w_shift     = (r_state == ST_START) || (r_state == ST_SHIFT) || (r_state == ST_RECV);
    assign w_sin       = (r_state == ST_RECV) ? MISO : 1'b0;

`ifdef SPI_MASTER_RDCHK_EN
    logic r_rd_armed;
    logic r_seq_err;

    assign w_drop  = (cmd == CMD_RD_DATA) && !r_rd_armed;
    assign seq_err = r_seq_err;

    // Track rd-addr / rd-data pairing; an unpaired rd-data sets the sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_armed <= 1'b0;
            r_seq_err  <= 1'b0;
        end else if (w_handshake) begin
            if (cmd == CMD_RD_ADDR) begin
                r_rd_armed <= 1'b1;
            end else if (cmd == CMD_RD_DATA) begin
                r_rd_armed <= 1'b0;
            end
            if (w_drop) begin
                r_seq_err <= 1'b1;
            end
        end
    end
`else
    assign w_drop  = 1'b0;
    assign seq_err = 1'b0;
`endif

    // Frame sequencer with all pin-level outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_is_read   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_handshake) begin
                        r_cmd_ready <= 1'b0;
                        r_is_read   <= (cmd == CMD_RD_DATA) && !w_drop;
                        r_mosi      <= 1'b0;
                        r_cnt       <= '0;
                        if (w_drop) begin
                            // Dropped command: no frame, SS_n stays high.
                            r_state <= ST_END;
                        end else begin
                            r_state <= ST_START;
                            r_ss_n  <= 1'b0;
                        end
                    end
                end
                ST_START: begin
                    r_state <= ST_SHIFT;
                    r_mosi  <= w_sout;
                    r_cnt   <= '0;
                end
                ST_SHIFT: begin
                    if (r_cnt == SHIFT_LAST) begin
                        r_cnt  <= '0;
                        r_mosi <= 1'b0;
                        if (r_is_read) begin
                            r_state <= ST_TURN;
                        end else begin
                            r_state <= ST_END;
                            r_ss_n  <= 1'b1;
                        end
                    end else begin
                        r_cnt  <= r_cnt + 4'd1;
                        r_mosi <= w_sout;
                    end
                end
                ST_TURN: begin
                    if (r_cnt == TURN_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_RECV;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_RECV: begin
                    if (r_cnt == RECV_LAST) begin
                        r_cnt       <= '0;
                        r_state     <= ST_END;
                        r_ss_n      <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_rx_byte;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_END: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_ss_n      <= 1'b1;
                    r_mosi      <= 1'b0;
                    r_cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    spi_master_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (make_frame(cmd, cmd_data)),
        .i_shift    (w_shift),
        .i_sin      (w_sin),
        .o_sout     (w_sout),
        .o_rx_byte  (w_rx_byte)
    );

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign SS_n      = r_ss_n;
    assign MOSI      = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (TURNAROUND 2, 1, 15) checked every
// cycle against an expected per-cycle waveform built from the frame rules.
`timescale 1ns/1ps
module tb_spi_master;
    import spi_pkg::*;

    localparam int NDUT = 3;
`ifdef SPI_MASTER_RDCHK_EN
    localparam bit RDCHK = 1'b1;
`else
    localparam bit RDCHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst       [NDUT];
    logic       cmd_valid [NDUT];
    logic [1:0] cmd       [NDUT];
    logic [7:0] cmd_data  [NDUT];
    logic       miso      [NDUT];
    logic       cmd_ready [NDUT];
    logic       rsp_valid [NDUT];
    logic [7:0] rsp_data  [NDUT];
    logic       ss_n      [NDUT];
    logic       mosi      [NDUT];
    logic       seq_err   [NDUT];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            spi_master #(.TURNAROUND(gi == 0 ? 2 : (gi == 1 ? 1 : 15))) u_dut (
                .clk       (clk),
                .rst       (rst[gi]),
                .cmd_valid (cmd_valid[gi]),
                .cmd_ready (cmd_ready[gi]),
                .cmd       (cmd[gi]),
                .cmd_data  (cmd_data[gi]),
                .rsp_valid (rsp_valid[gi]),
                .rsp_data  (rsp_data[gi]),
                .SS_n      (ss_n[gi]),
                .MOSI      (mosi[gi]),
                .MISO      (miso[gi]),
                .seq_err   (seq_err[gi])
            );
        end
    endgenerate

    function automatic int turn_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
    endfunction

    // Reference model state per instance.
    logic [7:0] last_rsp    [NDUT];
    bit         rd_flag     [NDUT];
    bit         exp_seq_err [NDUT];
    int         hi_run      [NDUT];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ss;
        logic       mo;
        logic       rv;
        logic [7:0] rd;
        logic       drv;
        logic       mb;
    } cyc_t;

    typedef struct {
        logic [1:0] c;
        logic [7:0] dat;
        logic [7:0] sb;
        int         exp_low;
        int         exp_rv;
    } vec_t;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    task automatic observe_ss(input int d);
        if (ss_n[d] === 1'b1) hi_run[d]++;
        else hi_run[d] = 0;
    endtask

    // Hold reset for three edges, checking the reset state, then release.
    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        cmd_valid[d] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ss_n", d, ss_n[d], 1'b1);
        chk("rst_mosi", d, mosi[d], 1'b0);
        chk("rst_rsp_valid", d, rsp_valid[d], 1'b0);
        chk("rst_rsp_data", d, rsp_data[d], 8'h00);
        chk("rst_seq_err", d, seq_err[d], 1'b0);
        chk("rst_cmd_ready", d, cmd_ready[d], 1'b0);
        rst[d] = 1'b0;
        last_rsp[d] = 8'h00;
        rd_flag[d] = 1'b0;
        exp_seq_err[d] = 1'b0;
        hi_run[d] = 99;
        @(negedge clk);
        chk("ready_after_rst", d, cmd_ready[d], 1'b1);
    endtask

    // Issue one command, then compare every cycle of the resulting frame
    // against a waveform derived from the frame rules. Returns at the first
    // negedge after the END cycle.
    task automatic do_cmd(input int d, input logic [1:0] c, input logic [7:0] dat,
                          input logic [7:0] sb, input bit hold,
                          output int low_cnt, output int rv_cnt);
        cyc_t q[$];
        logic [9:0] fr;
        bit drop;
        bit ok;
        int t;
        t = turn_of(d);
        fr = {c, dat};
        low_cnt = 0;
        rv_cnt = 0;
        cmd_valid[d] = 1'b1;
        cmd[d] = c;
        cmd_data[d] = dat;
        ok = 1'b0;
        for (int w = 0; w < 40; w++) begin
            miso[d] = 1'($urandom);
            observe_ss(d);
            if (cmd_ready[d] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("handshake", d, 32'(ok), 1);
        if (!ok) begin
            cmd_valid[d] = 1'b0;
            return;
        end
        chk("ss_gap_ge2", d, 32'(hi_run[d] >= 2), 1);

        drop = RDCHK && (c == CMD_RD_DATA) && !rd_flag[d];
        if (c == CMD_RD_ADDR) rd_flag[d] = 1'b1;
        else if (c == CMD_RD_DATA) rd_flag[d] = 1'b0;
        if (drop) exp_seq_err[d] = 1'b1;

        if (drop) begin
            q.push_back('{1'b1, 1'b0, 1'b0, last_rsp[d], 1'b0, 1'b0});
        end else begin
            q.push_back('{1'b0, 1'b0, 1'b0, last_rsp[d], 1'b0, 1'b0});
            for (int i = 9; i >= 0; i--)
                q.push_back('{1'b0, fr[i], 1'b0, last_rsp[d], 1'b0, 1'b0});
            if (c == CMD_RD_DATA) begin
                for (int i = 0; i < t; i++)
                    q.push_back('{1'b0, 1'b0, 1'b0, last_rsp[d], 1'b0, 1'b0});
                for (int j = 7; j >= 0; j--)
                    q.push_back('{1'b0, 1'b0, 1'b0, last_rsp[d], 1'b1, sb[j]});
                last_rsp[d] = sb;
            end
            q.push_back('{1'b1, 1'b0, c == CMD_RD_DATA, last_rsp[d], 1'b0, 1'b0});
        end

        @(negedge clk);
        if (!hold) cmd_valid[d] = 1'b0;
        cmd[d] = 2'($urandom);
        cmd_data[d] = 8'($urandom);
        foreach (q[i]) begin
            miso[d] = q[i].drv ? q[i].mb : 1'($urandom);
            chk("ss_n", d, ss_n[d], q[i].ss);
            chk("mosi", d, mosi[d], q[i].mo);
            chk("rsp_valid", d, rsp_valid[d], q[i].rv);
            chk("rsp_data", d, rsp_data[d], q[i].rd);
            chk("cmd_ready_busy", d, cmd_ready[d], 1'b0);
            chk("seq_err", d, seq_err[d], exp_seq_err[d]);
            if (ss_n[d] === 1'b0) low_cnt++;
            if (rsp_valid[d] === 1'b1) rv_cnt++;
            observe_ss(d);
            @(negedge clk);
        end
        cmd[d] = c;
        cmd_data[d] = dat;
        $display("cmd dut%0d c=%0d data=%02h slave=%02h: ss_low=%0d rsp_pulses=%0d rsp_data=%02h",
                 d, c, dat, sb, low_cnt, rv_cnt, rsp_data[d]);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [5];
        int low, rv, ok;

        tbl[0] = '{2'b00, 8'h3C, 8'h00, 11, 0};
        tbl[1] = '{2'b01, 8'h5A, 8'h00, 11, 0};
        tbl[2] = '{2'b10, 8'h3C, 8'h00, 11, 0};
        tbl[3] = '{2'b11, 8'h00, 8'hA5, 21, 1};
        tbl[4] = '{2'b10, 8'h81, 8'h00, 11, 0};

        for (int d = 0; d < NDUT; d++) begin
            rst[d] = 1'b1;
            cmd_valid[d] = 1'b0;
            cmd[d] = 2'b00;
            cmd_data[d] = 8'h00;
            miso[d] = 1'b0;
            hi_run[d] = 99;
        end
        for (int d = 0; d < NDUT; d++) do_reset(d);

        // rd-data straight after reset: dropped with the read check, framed without.
        do_cmd(0, CMD_RD_DATA, 8'h00, 8'h5A, 1'b0, low, rv);
        chk("rdchk_low", 0, low, RDCHK ? 0 : 21);
        chk("rdchk_rv", 0, rv, RDCHK ? 0 : 1);
        chk("rdchk_seq_err", 0, seq_err[0], RDCHK ? 1'b1 : 1'b0);

        // Reset clears the sticky error.
        do_reset(0);

        // Table-driven frames on the TURNAROUND=2 instance.
        for (int i = 0; i < 5; i++) begin
            do_cmd(0, tbl[i].c, tbl[i].dat, tbl[i].sb, 1'b0, low, rv);
            chk("tbl_low", i, low, tbl[i].exp_low);
            chk("tbl_rv", i, rv, tbl[i].exp_rv);
            if (tbl[i].exp_rv == 1) chk("tbl_rdata", i, rsp_data[0], tbl[i].sb);
        end

        // Back-to-back with cmd_valid held high across four commands.
        do_cmd(0, CMD_WR_ADDR, 8'h11, 8'h00, 1'b1, low, rv);
        chk("b2b_low0", 0, low, 11);
        do_cmd(0, CMD_RD_ADDR, 8'h22, 8'h00, 1'b1, low, rv);
        chk("b2b_low1", 0, low, 11);
        do_cmd(0, CMD_RD_DATA, 8'h33, 8'hC6, 1'b1, low, rv);
        chk("b2b_low2", 0, low, 21);
        do_cmd(0, CMD_WR_DATA, 8'h44, 8'h00, 1'b0, low, rv);
        chk("b2b_low3", 0, low, 11);

        // Reset in the middle of a read frame, while frame bit 5 is on MOSI.
        do_cmd(0, CMD_RD_ADDR, 8'h07, 8'h00, 1'b0, low, rv);
        cmd_valid[0] = 1'b1;
        cmd[0] = CMD_RD_DATA;
        cmd_data[0] = 8'h20;
        ok = 0;
        for (int w = 0; w < 40; w++) begin
            if (cmd_ready[0] === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("abort_handshake", 0, ok, 1);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_mosi_b5", 0, mosi[0], 1'b1);
        chk("abort_ss_low", 0, ss_n[0], 1'b0);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("abort_ss_n", 0, ss_n[0], 1'b1);
        chk("abort_rv", 0, rsp_valid[0], 1'b0);
        chk("abort_rdata", 0, rsp_data[0], 8'h00);
        chk("abort_ready", 0, cmd_ready[0], 1'b0);
        rst[0] = 1'b0;
        last_rsp[0] = 8'h00;
        rd_flag[0] = 1'b0;
        exp_seq_err[0] = 1'b0;
        hi_run[0] = 99;
        @(negedge clk);
        chk("abort_ready_back", 0, cmd_ready[0], 1'b1);
        rv = 0;
        for (int i = 0; i < 25; i++) begin
            miso[0] = 1'($urandom);
            if (rsp_valid[0] === 1'b1 || ss_n[0] !== 1'b1) rv++;
            @(negedge clk);
        end
        chk("abort_quiet", 0, rv, 0);
        do_cmd(0, CMD_RD_ADDR, 8'h20, 8'h00, 1'b0, low, rv);
        do_cmd(0, CMD_RD_DATA, 8'h00, 8'h3C, 1'b0, low, rv);
        chk("after_abort_rv", 0, rv, 1);
        chk("after_abort_rdata", 0, rsp_data[0], 8'h3C);

        // Turnaround extremes.
        for (int d = 1; d < NDUT; d++) begin
            do_cmd(d, CMD_RD_ADDR, 8'h3C, 8'h00, 1'b0, low, rv);
            do_cmd(d, CMD_RD_DATA, 8'h00, 8'hA5, 1'b0, low, rv);
            chk("turn_low", d, low, 19 + turn_of(d));
            chk("turn_rdata", d, rsp_data[d], 8'hA5);
        end

        // Randomized commands across all instances.
        for (int n = 0; n < 60; n++) begin
            int d;
            d = $urandom_range(0, NDUT - 1);
            do_cmd(d, 2'($urandom), 8'($urandom), 8'($urandom), 1'b0, low, rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
